inst_assembler: RTL
===================

Name: inst_assembler

Overview:
- Producer end of the instruction stream that the control decoder consumes.
- Accepts RV32I instruction fields over a valid/ready handshake and assembles the 32-bit instruction word.
- Writes each word sequentially into instruction memory through its write port; used by the debug/loader path to place test programs without a toolchain.
- Covers exactly the instruction classes the control decoder recognises.

Parameters:
ADDR_W, 8, word-address width of the instruction-memory write port.
BASE_DEF, 0, start address used when start_base_sel=0.

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  reset, synchronous, active-low
start  input  1  one-cycle pulse, opens a load session (IDLE only)
start_base_sel  input  1  0: start at BASE_DEF; 1: start at start_base
start_base  input  ADDR_W  explicit start word address
stop  input  1  closes the session
in_valid  input  1  field bundle valid
in_ready  output  1  block accepts a bundle this cycle
cls  input  3  0 R, 1 I-alu, 2 S, 3 B, 4 LOAD, 5 AUIPC, 6 LUI, 7 JAL
funct3  input  3  funct3 field
f7b5  input  1  R: selects 0100000 funct7; I shift (funct3 001/101): sets inst[30]
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
imm  input  32  byte-offset or immediate value; U classes use imm[31:12]
im_we  output  1  instruction-memory write enable
im_addr  output  ADDR_W  word address
im_wdata  output  32  assembled instruction
count  output  ADDR_W+1  words written this session
busy  output  1  session open
done  output  1  one-cycle pulse when the session closes
err  output  1  one-cycle pulse, IMM_CHECK_EN only

Behaviour:
- Reset (rstn=0 at an edge):
  - State goes to IDLE.
  - im_we, in_ready, busy, done and err are 0.
  - im_addr, im_wdata and count are 0.
  - Reset mid-write: im_we drops at that edge and the word is not written.
- State machine: IDLE, ARMED, WRITE, FULL.
- IDLE:
  - in_ready=0.
  - start moves the block to ARMED, loads the address counter (BASE_DEF or start_base) and clears count.
- ARMED:
  - in_ready=1, busy=1.
  - Handshake (in_valid & in_ready): word encoded combinationally, registered into im_wdata, next state WRITE.
- WRITE:
  - Lasts exactly one cycle; im_we=1 with im_addr/im_wdata stable.
  - Write is visible one cycle after the handshake cycle; throughput is 1 word per 2 cycles.
  - On leaving WRITE: count+1 and im_addr+1.
  - If the address written was all-ones, next state is FULL, im_addr is left at all-ones and does not wrap; otherwise next state is ARMED.
- FULL: in_ready=0, busy=1; waits for stop.
- stop handling:
  - In ARMED or FULL, stop goes to IDLE with done=1 for one cycle.
  - In WRITE, stop is latched; the write completes, then the block goes to IDLE with done.
  - stop together with in_valid in ARMED: stop wins and the bundle is not accepted.
- start outside IDLE is ignored.
- count holds its value after done until the next start.
- im_wdata holds the last word when im_we=0.
- Encoding, with opcodes matching the decoder:
  - R: {f7b5?0100000:0000000, rs2, rs1, funct3, rd, 0110011}.
  - I-alu: {imm[11:0], rs1, funct3, rd, 0010011}. For funct3 001/101, inst[31:25] = {0, f7b5, 00000} and inst[24:20] = imm[4:0].
  - LOAD: {imm[11:0], rs1, funct3, rd, 0000011}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
  - AUIPC / LUI: {imm[31:12], rd, 0010111 / 0110111}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
- Unused fields for a class are ignored. Without the optional check, immediate bits outside the field are silently dropped.

Optional Feature:
IMM_CHECK_EN
- Defined: at handshake, the immediate is range-checked.
  - I, LOAD, S: imm must equal sext(imm[11:0]).
  - B: imm must equal sext(imm[12:0]) with imm[0]=0.
  - JAL: imm must equal sext(imm[20:0]) with imm[0]=0.
  - AUIPC, LUI: imm[11:0] must be 0.
  - Shift I: imm[11:5] must be 0.
  - Violation: err=1 for one cycle, the bundle is consumed, no write, count unchanged, state stays ARMED.
- Undefined: err tied 0 and no check logic is instantiated.

Test Plan:
1. Reset, then start with base_sel=0, then addi x1,x0,5 (cls1, f3 000, rd1, imm 5) -> im_we one cycle after handshake, addr 0x00, data 0x00500093, count=1.
2. add x3,x1,x2 then sub (f7b5=1) -> addr 0/1, data 0x002081B3 then 0x402081B3.
3. sw x2,8(x1), beq x1,x2,+8, jal x1,+16, lui x5 imm 0x12345000 -> 0x0020A423, 0x00208463, 0x010000EF, 0x123452B7.
4. Start at start_base=0xFE, send 3 words -> writes at 0xFE and 0xFF, then FULL with in_ready=0 and the third bundle held; stop -> done pulse, count=2, IDLE.
5. stop asserted during WRITE, and stop together with in_valid in ARMED -> write completes then done; simultaneous bundle not accepted.
6. rstn low during WRITE -> no write at that edge, all outputs 0. With IMM_CHECK_EN: addi imm 0x800 -> err pulse, no im_we, count unchanged.

Source files
------------

// File: rtl/inst_assembler.sv
// inst_assembler: assembles RV32I field bundles into instruction words and writes them sequentially into instruction memory
// Ports: clk, rstn (synchronous, active-low); start/start_base_sel/start_base/stop control a load session;
//   in_valid/in_ready handshake carries cls/funct3/f7b5/rd/rs1/rs2/imm; im_we/im_addr/im_wdata form the memory write port;
//   count = words written this session, busy = session open, done = close pulse, err = immediate range-check pulse.
// Optional: define IMM_CHECK_EN to range-check immediates at handshake (err is tied 0 otherwise).
module inst_assembler #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_DEF = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              start_base_sel,
  input  logic [ADDR_W-1:0] start_base,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        cls,
  input  logic [2:0]        funct3,
  input  logic              f7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, ARMED, WRITE, FULL} state_t;
  state_t state;
  logic [31:0] word;
  logic shift, last, bad;
  assign shift = funct3[1:0] == 2'b01;
  assign last = &im_addr;
  always_comb begin
    word = '0;
    case (cls)
      3'd0: word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
      3'd1: word = shift ? {1'b0, f7b5, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011}
                         : {imm[11:0], rs1, funct3, rd, 7'b0010011};
      3'd2: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      3'd3: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      3'd4: word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      3'd5: word = {imm[31:12], rd, 7'b0010111};
      3'd6: word = {imm[31:12], rd, 7'b0110111};
      default: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endcase
  end
`ifdef IMM_CHECK_EN
  always_comb begin
    bad = 1'b0;
    case (cls)
      3'd1: bad = shift ? |imm[31:5] : imm[31:11] != {21{imm[11]}};
      3'd2, 3'd4: bad = imm[31:11] != {21{imm[11]}};
      3'd3: bad = imm[31:12] != {20{imm[12]}} || imm[0];
      3'd5, 3'd6: bad = |imm[11:0];
      3'd7: bad = imm[31:20] != {12{imm[20]}} || imm[0];
      default: bad = 1'b0;
    endcase
  end
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      im_we <= 1'b0;
      im_addr <= '0;
      im_wdata <= '0;
      count <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      im_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ARMED;
          in_ready <= 1'b1;
          busy <= 1'b1;
          im_addr <= start_base_sel ? start_base : BASE_DEF;
          count <= '0;
        end
        ARMED: if (stop) begin
          state <= IDLE;
          in_ready <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end else if (in_valid) begin
          if (bad) err <= 1'b1;
          else begin
            state <= WRITE;
            in_ready <= 1'b0;
            im_we <= 1'b1;
            im_wdata <= word;
          end
        end
        // a stop seen while the word is out still lets this write finish
        WRITE: begin
          count <= count + 1'b1;
          im_addr <= last ? im_addr : im_addr + 1'b1;
          state <= stop ? IDLE : last ? FULL : ARMED;
          in_ready <= !stop && !last;
          busy <= !stop;
          done <= stop;
        end
        FULL: if (stop) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule
